// File: rtl/ecall_uart_tx.sv
// ecall_uart_tx: consumer end of the CPU ecall output channel.
// Each strobed 32-bit word is queued in a small FIFO and printed on the UART
// TX line as 8 lowercase hex digits (MSB nibble first) followed by LF, 8N1.
// The ecall channel cannot be stalled, so a strobe that finds the FIFO full
// (and no pop on the same edge) is dropped and flagged in a sticky bit.
module ecall_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ecall_ready,
    input  logic [31:0] i_ecall_data,
    input  logic        i_clr_overflow,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic        o_fifo_full,
    output logic        o_overflow
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]        LAST_CHAR = 4'd8;
    localparam logic [7:0]        ASCII_LF  = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Nibble to lowercase ASCII hex digit.
    function automatic logic [7:0] nib_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h57 + {4'h0, nib};   // 0x61 - 10
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [3:0]          char_idx_q, char_idx_d;
    logic [7:0]          char_q, char_d;
    logic [31:0]         word_q, word_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         mem_q [FIFO_DEPTH];

    logic                bit_end_s;
    logic                frame_done_s;
    logic                fifo_empty_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic [31:0]         head_s;

    assign head_s       = mem_q[rd_ptr_q];
    assign bit_end_s    = (bit_cnt_q == BIT_LAST);
    assign frame_done_s = (state_q == S_STOP) && bit_end_s && (char_idx_q == LAST_CHAR);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    // A word is popped either from idle or straight out of the LF stop bit,
    // so consecutive words go out with no idle gap.
    assign pop_s        = !fifo_empty_s && ((state_q == S_IDLE) || frame_done_s);
    assign push_s       = i_ecall_ready && (!full_q || pop_s);
    assign drop_s       = i_ecall_ready && !push_s;

    // FIFO pointers, occupancy, full flag and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        full_d     = (count_d == DEPTH_C);
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Serializer FSM: bit timing, character sequencing and line value.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        char_d     = char_q;
        word_d     = word_q;

        if (state_q == S_IDLE) begin
            bit_cnt_d = {BCNT_W{1'b0}};
        end else if (bit_end_s) begin
            bit_cnt_d = {BCNT_W{1'b0}};
        end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d    = S_START;
                    char_idx_d = 4'd0;
                    char_d     = nib_ascii(head_s[31:28]);
                    word_d     = {head_s[27:0], 4'h0};
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d   = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (char_idx_q == LAST_CHAR) begin
                        if (pop_s) begin
                            state_d    = S_START;
                            char_idx_d = 4'd0;
                            char_d     = nib_ascii(head_s[31:28]);
                            word_d     = {head_s[27:0], 4'h0};
                        end else begin
                            state_d    = S_IDLE;
                        end
                    end else begin
                        state_d    = S_START;
                        char_idx_d = char_idx_q + 4'd1;
                        if (char_idx_q == 4'd7) begin
                            char_d = ASCII_LF;
                        end else begin
                            char_d = nib_ascii(word_q[31:28]);
                            word_d = {word_q[27:0], 4'h0};
                        end
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line value is registered from the next state so it changes on the
        // same edge that the state does.
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = char_d[bit_idx_d];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}});
    end

    // Control and status registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= {BCNT_W{1'b0}};
            bit_idx_q  <= 3'd0;
            char_idx_q <= 4'd0;
            char_q     <= 8'h00;
            word_q     <= 32'h0000_0000;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            char_q     <= char_d;
            word_q     <= word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage: write the strobed word at the write pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= i_ecall_data;
        end
    end

    assign o_uart_tx   = tx_q;
    assign o_busy      = busy_q;
    assign o_fifo_full = full_q;
    assign o_overflow  = overflow_q;

endmodule
